// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
package seg7_pkg;

  // Active-low segments a..g, all off
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SHOW
  } state_t;

  // Ceiling log2, at least 1 bit for any v >= 2
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/decoder_7seg.sv
// Hex nibble to common-anode (active-low) segment pattern, a..g left to right.
module decoder_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [0:6] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (nibble)
      4'h0: seg_c = 7'b0000001;
      4'h1: seg_c = 7'b1001111;
      4'h2: seg_c = 7'b0010010;
      4'h3: seg_c = 7'b0000110;
      4'h4: seg_c = 7'b1001100;
      4'h5: seg_c = 7'b0100100;
      4'h6: seg_c = 7'b0100000;
      4'h7: seg_c = 7'b0001111;
      4'h8: seg_c = 7'b0000000;
      4'h9: seg_c = 7'b0000100;
      4'hA: seg_c = 7'b0001000;
      4'hB: seg_c = 7'b1100000;
      4'hC: seg_c = 7'b0110001;
      4'hD: seg_c = 7'b1000010;
      4'hE: seg_c = 7'b0110000;
      4'hF: seg_c = 7'b0111000;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank with
// frame-synchronous value update, blanking gap and leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::state_t, seg7_pkg::SEG_BLANK, seg7_pkg::clog2;
#(
  parameter int unsigned NDIG = 4,
  parameter int unsigned DIV  = 50000,
  parameter int unsigned GAP  = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              lz_en,
  input  logic              load_valid,
  input  logic [4*NDIG-1:0] load_value,
  output logic              load_ready,
  output logic [0:6]        HEX,
  output logic [NDIG-1:0]   DIG_N,
  output logic              frame_done
);

  localparam int unsigned CW = clog2(DIV);
  localparam int unsigned IW = clog2(NDIG);
  localparam int unsigned VW = 4 * NDIG;

  state_t          state;
  logic [CW-1:0]   div_cnt;
  logic [IW-1:0]   idx;
  logic [VW-1:0]   shadow;
  logic [VW-1:0]   pend_buf;
  logic            pend;

  logic            slot_end_c;
  logic            commit_c;
  logic            accept_c;
  logic [3:0]      nib_c;
  logic [0:6]      seg_c;
  logic [NDIG-1:0] lz_blank_c;

  assign slot_end_c = (state == seg7_pkg::SHOW) && (div_cnt == CW'(DIV - 1));
  assign commit_c   = en && slot_end_c && (idx == IW'(NDIG - 1));
  assign accept_c   = load_valid && load_ready;
  assign nib_c      = shadow[{idx, 2'b00} +: 4];

  // Digit k>0 blanks when it and every more-significant nibble are zero
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank_c = '0;
    for (int k = NDIG - 1; k > 0; k--) begin
      zero_above    = zero_above && (shadow[4*k +: 4] == 4'h0);
      lz_blank_c[k] = lz_en && zero_above;
    end
  end

  decoder_7seg u_dec (
    .nibble (nib_c),
    .seg_c  (seg_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= seg7_pkg::IDLE;
      idx        <= '0;
      div_cnt    <= '0;
      shadow     <= '0;
      pend_buf   <= '0;
      pend       <= 1'b0;
      load_ready <= 1'b1;
      HEX        <= SEG_BLANK;
      DIG_N      <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= commit_c;

      if (!en) begin
        state   <= seg7_pkg::IDLE;
        idx     <= '0;
        div_cnt <= '0;
      end else begin
        case (state)
          seg7_pkg::IDLE: begin
            state   <= seg7_pkg::GAP;
            idx     <= '0;
            div_cnt <= '0;
          end
          seg7_pkg::GAP: begin
            div_cnt <= div_cnt + CW'(1);
            if (div_cnt == CW'(GAP - 1)) state <= seg7_pkg::SHOW;
          end
          seg7_pkg::SHOW: begin
            if (slot_end_c) begin
              div_cnt <= '0;
              idx     <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
              state   <= seg7_pkg::GAP;
            end else begin
              div_cnt <= div_cnt + CW'(1);
            end
          end
          default: state <= seg7_pkg::IDLE;
        endcase
      end

      // A pending value moves to the display copy only at a frame boundary or while dark
      if (accept_c) begin
        pend_buf   <= load_value;
        pend       <= 1'b1;
        load_ready <= 1'b0;
      end else if (pend && (commit_c || state == seg7_pkg::IDLE)) begin
        shadow     <= pend_buf;
        pend       <= 1'b0;
        load_ready <= 1'b1;
      end

      if (en && state == seg7_pkg::SHOW) begin
        DIG_N <= ~(NDIG'(1) << idx);
        HEX   <= lz_blank_c[idx] ? SEG_BLANK : seg_c;
      end else begin
        DIG_N <= '1;
        HEX   <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed and random stimulus against a cycle-position
// model of the scan, checked every clock.
module tb_seg7_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int GAP   = 2;
  localparam int FRAME = NDIG * DIV;
  localparam logic [0:6] BLANK = 7'b1111111;

  logic            clk;
  logic            rst;
  logic            en;
  logic            lz_en;
  logic            load_valid;
  logic [15:0]     load_value;
  logic            load_ready;
  logic [0:6]      HEX;
  logic [NDIG-1:0] DIG_N;
  logic            frame_done;

  int vectors     = 0;
  int miscompares = 0;

  // Model: cycles since scan start (-1 = dark/idle), displayed and pending values
  int          run_pos;
  logic [15:0] m_shadow;
  logic [15:0] m_pend_buf;
  logic        m_pend;

  seg7_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lz_en      (lz_en),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .HEX        (HEX),
    .DIG_N      (DIG_N),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Segment pattern from the list of lit segment letters
  function automatic logic [0:6] seg_of(input logic [3:0] n);
    string lit;
    logic [0:6] s;
    case (n)
      4'h0: lit = "abcdef";
      4'h1: lit = "bc";
      4'h2: lit = "abdeg";
      4'h3: lit = "abcdg";
      4'h4: lit = "bcfg";
      4'h5: lit = "acdfg";
      4'h6: lit = "acdefg";
      4'h7: lit = "abc";
      4'h8: lit = "abcdefg";
      4'h9: lit = "abcdfg";
      4'hA: lit = "abcefg";
      4'hB: lit = "cdefg";
      4'hC: lit = "adef";
      4'hD: lit = "bcdeg";
      4'hE: lit = "adefg";
      default: lit = "aefg";
    endcase
    s = BLANK;
    for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b0;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run_pos    = -1;
    m_shadow   = '0;
    m_pend_buf = '0;
    m_pend     = 1'b0;
  endtask

  // One clock: predict from pre-edge model + inputs, advance model, check all outputs
  task automatic tick();
    logic [0:6]      ehex;
    logic [NDIG-1:0] edig;
    logic            efd, accept, commit, en_s;
    logic [15:0]     lv;
    int              k;
    en_s = en;
    lv   = load_value;
    ehex = BLANK;
    edig = '1;
    if (en_s && run_pos >= 0 && (run_pos % DIV) >= GAP) begin
      k = (run_pos / DIV) % NDIG;
      edig[k] = 1'b0;
      if (lz_en && k > 0 && (m_shadow >> (4 * k)) == 16'h0) ehex = BLANK;
      else ehex = seg_of(m_shadow[4*k +: 4]);
    end
    efd    = en_s && run_pos >= 0 && (run_pos % FRAME) == FRAME - 1;
    accept = load_valid && !m_pend;
    commit = efd || run_pos < 0;
    @(posedge clk);
    if (accept) begin
      m_pend_buf = lv;
      m_pend     = 1'b1;
    end else if (m_pend && commit) begin
      m_shadow = m_pend_buf;
      m_pend   = 1'b0;
    end
    if (!en_s) run_pos = -1;
    else run_pos++;
    #1;
    chk("hex", 32'(HEX), 32'(ehex));
    chk("dig_n", 32'(DIG_N), 32'(edig));
    chk("frame_done", 32'(frame_done), 32'(efd));
    chk("load_ready", 32'(load_ready), 32'(!m_pend));
  endtask

  task automatic load(input logic [15:0] v);
    load_value = v;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  // Advance until the model scan position modulo m equals p
  task automatic wait_pos(input int p, input int m);
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      if (run_pos >= 0 && run_pos % m == p) return;
      tick();
    end
    vectors++;
    miscompares++;
    $error("FAIL wait_pos: position %0d mod %0d never reached", p, m);
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    lz_en      = 1'b0;
    load_valid = 1'b0;
    load_value = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hex", 32'(HEX), 32'h7f);
    chk("rst_dig_n", 32'(DIG_N), 32'hf);
    chk("rst_ready", 32'(load_ready), 32'h1);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    #2 rst = 1'b0;
    repeat (3) tick();

    // Plain scan of 1234
    load(16'h1234);
    repeat (2) tick();
    en = 1'b1;
    repeat (70) tick();

    // Leading-zero blanking
    lz_en = 1'b1;
    load(16'h0050);
    repeat (80) tick();
    load(16'h0000);
    repeat (70) tick();

    // Mid-frame load, ignored second offer, visible only next frame
    lz_en = 1'b0;
    wait_pos(10, FRAME);
    load_value = 16'hABCD;
    load_valid = 1'b1;
    tick();
    load_value = 16'h5555;
    repeat (3) tick();
    chk("ready_low_while_pending", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME && frame_done !== 1'b1; i++) tick();
    chk("frame_done_seen", 32'(frame_done), 32'h1);
    for (int i = 0; i < 2 * DIV && DIG_N !== 4'b1110; i++) tick();
    chk("dig0_sel", 32'(DIG_N), 32'he);
    chk("dig0_shows_D", 32'(HEX), 32'(7'b1000010));

    // Load accepted in the commit cycle stays pending for a frame
    wait_pos(FRAME - 1, FRAME);
    load(16'h9876);
    repeat (80) tick();

    // en dropped mid-SHOW, then restarted
    wait_pos(DIV + GAP + 2, FRAME);
    en = 1'b0;
    tick();
    chk("dark_after_en_drop", 32'(DIG_N), 32'hf);
    repeat (5) tick();
    en = 1'b1;
    repeat (40) tick();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      en         = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 99) == 0) lz_en = ~lz_en;
      load_valid = ($urandom_range(0, 7) == 0);
      load_value = 16'($urandom);
      tick();
    end
    load_valid = 1'b0;
    en         = 1'b1;
    lz_en      = 1'b0;
    repeat (40) tick();

    // Async reset while lit with a load pending
    wait_pos(GAP, DIV);
    load(16'h4321);
    chk("lit_before_rst", 32'(DIG_N != 4'hf), 32'h1);
    chk("pending_before_rst", 32'(load_ready), 32'h0);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_hex", 32'(HEX), 32'h7f);
    chk("async_rst_dig_n", 32'(DIG_N), 32'hf);
    chk("async_rst_ready", 32'(load_ready), 32'h1);
    chk("async_rst_frame_done", 32'(frame_done), 32'h0);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
